// File: rtl/sign_narrow_pkg.sv
// Shared widths, saturation constants, payload type and pointer-width helper for sign_narrow.
package sign_narrow_pkg;

  localparam int unsigned IN_W  = 32;
  localparam int unsigned OUT_W = 16;

  // Largest and smallest OUT_W-bit two's complement values
  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  // One buffered result: narrowed value plus its overflow flag
  typedef struct packed {
    logic             ovf;
    logic [OUT_W-1:0] data;
  } entry_t;

  // Pointer width for a buffer of 'depth' entries (at least one bit)
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sign_narrow_if.sv
// Producer/consumer stream bundle of the sign narrower.
interface sign_narrow_if
  import sign_narrow_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);

  logic             valid_i;
  logic             ready_o;
  logic [IN_W-1:0]  data_i;
  logic             sat_i;
  logic             valid_o;
  logic             ready_i;
  logic [OUT_W-1:0] data_o;
  logic             ovf_o;
  logic [CNT_W-1:0] ovf_cnt_o;
  logic             clr_cnt_i;

  modport slave (
    input  valid_i, data_i, sat_i, ready_i, clr_cnt_i,
    output ready_o, valid_o, data_o, ovf_o, ovf_cnt_o
  );

  modport master (
    output valid_i, data_i, sat_i, ready_i, clr_cnt_i,
    input  ready_o, valid_o, data_o, ovf_o, ovf_cnt_o
  );

endinterface

// File: rtl/sign_narrow_fifo.sv
// Small circular output buffer with registered full/empty flags.
module sign_narrow_fifo
  import sign_narrow_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic            do_push;
  logic            do_pop;

  // A push is refused when full even if a pop happens on the same edge
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Occupancy after this edge, used to register the flags
  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) count_nxt = count + CW'(1);
    if (do_pop && !do_push) count_nxt = count - CW'(1);
  end

  // Pointers, occupancy and flags; pointers wrap naturally (DEPTH is a power of 2)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == CW'(0));
    end
  end

  // Storage array
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/sign_narrow.sv
// Narrows signed IN_W values to OUT_W with truncate/saturate, buffers results, counts overflows.
module sign_narrow
  import sign_narrow_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  sign_narrow_if.slave  bus
);

  logic [IN_W-OUT_W:0] upper;
  logic                fit;
  entry_t              entry_c;
  entry_t              head;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [CNT_W-1:0]    ovf_cnt;

  assign upper = bus.data_i[IN_W-1:OUT_W-1];
  assign fit   = (&upper) || !(|upper);

  // Narrowed result and overflow flag for the word on the input
  always_comb begin
    entry_c.data = bus.data_i[OUT_W-1:0];
    entry_c.ovf  = 1'b0;
    if (!fit) begin
      entry_c.ovf = 1'b1;
      if (bus.sat_i) entry_c.data = bus.data_i[IN_W-1] ? SAT_NEG : SAT_POS;
    end
  end

  assign push = bus.valid_i && !full;
  assign pop  = bus.ready_i && !empty;

  sign_narrow_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (pop),
    .wdata (entry_c),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.ready_o   = !full;
  assign bus.valid_o   = !empty;
  assign bus.data_o    = empty ? '0 : head.data;
  assign bus.ovf_o     = !empty && head.ovf;
  assign bus.ovf_cnt_o = ovf_cnt;

  // Saturating overflow counter; clear wins over a same-cycle increment
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_cnt <= '0;
    end else if (bus.clr_cnt_i) begin
      ovf_cnt <= '0;
    end else if (push && entry_c.ovf && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sign_narrow.sv
// Directed bench for sign_narrow with a scoreboard queue and a reference narrowing model.
module tb_sign_narrow;

  localparam int unsigned TB_DEPTH = 2;
  localparam int unsigned TB_CNT_W = 16;

  typedef struct {
    logic [15:0] data;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sign_narrow_if #(.CNT_W(TB_CNT_W)) bus ();

  sign_narrow #(
    .DEPTH (TB_DEPTH),
    .CNT_W (TB_CNT_W)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  exp_t        sb [$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] cnt_m;
  bit          last_push;

  // Reference: range check on the signed value, not on bit patterns
  function automatic exp_t narrow_model(input logic [31:0] d, input logic s);
    exp_t   e;
    longint v;
    v      = longint'($signed(d));
    e.data = d[15:0];
    e.ovf  = 1'b0;
    if (v > 32767) begin
      e.ovf = 1'b1;
      if (s) e.data = 16'h7FFF;
    end else if (v < -32768) begin
      e.ovf = 1'b1;
      if (s) e.data = 16'h8000;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs at negedge, update model with this edge's handshakes
  task automatic step();
    bit   do_pop;
    bit   do_push;
    exp_t e;
    @(negedge clk);
    do_pop  = (sb.size() > 0) && (bus.ready_i === 1'b1);
    do_push = (bus.valid_i === 1'b1) && (sb.size() < TB_DEPTH);
    chk("valid_o", 32'(bus.valid_o), 32'(sb.size() > 0));
    chk("ready_o", 32'(bus.ready_o), 32'(sb.size() < TB_DEPTH));
    if (sb.size() > 0) begin
      chk("data_o", 32'(bus.data_o), 32'(sb[0].data));
      chk("ovf_o", 32'(bus.ovf_o), 32'(sb[0].ovf));
    end else begin
      chk("data_o_idle", 32'(bus.data_o), 32'h0);
      chk("ovf_o_idle", 32'(bus.ovf_o), 32'h0);
    end
    chk("ovf_cnt_o", 32'(bus.ovf_cnt_o), 32'(cnt_m));
    if (do_pop) void'(sb.pop_front());
    e = narrow_model(bus.data_i, bus.sat_i);
    if (do_push) sb.push_back(e);
    if (bus.clr_cnt_i) cnt_m = '0;
    else if (do_push && e.ovf && (cnt_m != 16'hFFFF)) cnt_m = cnt_m + 16'd1;
    last_push = do_push;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic s);
    bus.valid_i = 1'b1;
    bus.data_i  = d;
    bus.sat_i   = s;
    for (int i = 0; i < 16; i++) begin
      step();
      if (last_push) break;
    end
    chk("send_accepted", 32'(last_push), 32'h1);
    bus.valid_i = 1'b0;
  endtask

  task automatic drain();
    bus.ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (sb.size() == 0) break;
      step();
    end
    step();
    chk("drained_valid_o", 32'(bus.valid_o), 32'h0);
    bus.ready_i = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.valid_i   = 1'b0;
    bus.data_i    = '0;
    bus.sat_i     = 1'b0;
    bus.ready_i   = 1'b0;
    bus.clr_cnt_i = 1'b0;
    cnt_m         = '0;
    last_push     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_o", 32'(bus.valid_o), 32'h0);
    chk("rst_ready_o", 32'(bus.ready_o), 32'h1);
    chk("rst_data_o", 32'(bus.data_o), 32'h0);
    chk("rst_ovf_cnt_o", 32'(bus.ovf_cnt_o), 32'h0);
    rst = 1'b0;
    step();

    // Async reset with two words buffered
    send(32'h0001_2345, 1'b1);
    send(32'hFFFE_0000, 1'b1);
    chk("pre_rst_cnt", 32'(bus.ovf_cnt_o), 32'h2);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid_o", 32'(bus.valid_o), 32'h0);
    chk("mid_rst_data_o", 32'(bus.data_o), 32'h0);
    chk("mid_rst_ovf_o", 32'(bus.ovf_o), 32'h0);
    chk("mid_rst_ovf_cnt_o", 32'(bus.ovf_cnt_o), 32'h0);
    chk("mid_rst_ready_o", 32'(bus.ready_o), 32'h1);
    sb.delete();
    cnt_m = '0;
    #1 rst = 1'b0;
    step();

    // Values that fit exactly at the boundaries
    send(32'hFFFF_8000, 1'b0);
    chk("fit_neg_data", 32'(bus.data_o), 32'h8000);
    send(32'h0000_7FFF, 1'b0);
    drain();
    chk("fit_cnt", 32'(bus.ovf_cnt_o), 32'h0);

    // Overflows, saturated and truncated
    bus.ready_i = 1'b1;
    send(32'h0001_2345, 1'b1);
    send(32'hFFFE_0000, 1'b1);
    send(32'h0001_2345, 1'b0);
    step();
    chk("ovf_cnt_3", 32'(bus.ovf_cnt_o), 32'h3);
    drain();

    // Backpressure: third word held until a slot frees
    send(32'h0000_0AAA, 1'b0);
    send(32'h0000_0BBB, 1'b0);
    bus.valid_i = 1'b1;
    bus.data_i  = 32'h0000_0CCC;
    bus.sat_i   = 1'b0;
    step();
    chk("bp_blocked", 32'(last_push), 32'h0);
    bus.ready_i = 1'b1;
    step();
    chk("bp_pop_no_push", 32'(last_push), 32'h0);
    bus.ready_i = 1'b0;
    step();
    chk("bp_c_pushed", 32'(last_push), 32'h1);
    bus.valid_i = 1'b0;
    drain();

    // Simultaneous push and pop with one word buffered
    send(32'h0000_1111, 1'b0);
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = 32'hFFFF_F222;
    step();
    chk("simul_push", 32'(last_push), 32'h1);
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    step();
    chk("simul_data", 32'(bus.data_o), 32'hF222);
    drain();

    // Counter saturation and clear priority
    bus.clr_cnt_i = 1'b1;
    step();
    bus.clr_cnt_i = 1'b0;
    bus.ready_i   = 1'b1;
    bus.valid_i   = 1'b1;
    bus.data_i    = 32'h4000_0000;
    bus.sat_i     = 1'b1;
    repeat (65534) step();
    bus.valid_i = 1'b0;
    step();
    chk("cnt_fffe", 32'(bus.ovf_cnt_o), 32'hFFFE);
    send(32'h8000_0000, 1'b1);
    send(32'h7FFF_FFFF, 1'b0);
    send(32'h0002_0000, 1'b1);
    step();
    chk("cnt_sat", 32'(bus.ovf_cnt_o), 32'hFFFF);
    bus.clr_cnt_i = 1'b1;
    send(32'h0002_0000, 1'b1);
    bus.clr_cnt_i = 1'b0;
    step();
    chk("cnt_clr", 32'(bus.ovf_cnt_o), 32'h0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
